// File: rtl/spi_stream_arbiter.sv
// spi_stream_arbiter: shares one SPI flash read controller between two
// streaming requesters. Stream 0 has priority. Each stream keeps its own
// running flash address.
//
// Optional feature macro: SPI_ARB_PREEMPT_EN
//   defined   - r0_start suspends an open stream 1 at a word boundary. Stream 1
//               resumes later at its saved address.
//   undefined - r0_start waits until stream 1 closes. r1_suspended stays 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rN_start / rN_addr          open (or restart) stream N at rN_addr and fetch a word
//   rN_next                     fetch the next word of stream N
//   rN_stop                     close stream N
//   rN_valid, rd_data           one-cycle word delivery to stream N
//   r1_suspended                stream 1 is open but does not own the flash
//   flash_start/continue/stop   one-cycle command pulses to the controller
//   flash_addr                  start address, valid with flash_start
//   flash_busy, flash_data      controller status and read data
module spi_stream_arbiter #(
  parameter int unsigned DATA_WIDTH_BYTES = 2,
  parameter int unsigned ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          r0_start,
  input  logic [ADDR_BITS-1:0]          r0_addr,
  input  logic                          r0_next,
  input  logic                          r0_stop,
  input  logic                          r1_start,
  input  logic [ADDR_BITS-1:0]          r1_addr,
  input  logic                          r1_next,
  input  logic                          r1_stop,
  output logic                          r0_valid,
  output logic                          r1_valid,
  output logic [8*DATA_WIDTH_BYTES-1:0] rd_data,
  output logic                          r1_suspended,
  output logic                          flash_start,
  output logic                          flash_continue,
  output logic                          flash_stop,
  output logic [ADDR_BITS-1:0]          flash_addr,
  input  logic                          flash_busy,
  input  logic [8*DATA_WIDTH_BYTES-1:0] flash_data
);

  localparam int unsigned DW = 8 * DATA_WIDTH_BYTES;

`ifdef SPI_ARB_PREEMPT_EN
  localparam bit PREEMPT_EN = 1'b1;
`else
  localparam bit PREEMPT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STOPPING} state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;         // stream that the flash session belongs to
  logic                 in_flash_q, in_flash_d;   // controller has an open read session
  logic [1:0]           open_q, open_d;           // stream logically open
  logic [1:0]           pstart_q, pstart_d;       // start requested, not yet issued
  logic [1:0]           pnext_q, pnext_d;         // next word requested, not yet issued
  logic [ADDR_BITS-1:0] cnt0_q, cnt0_d;           // next word address, stream 0
  logic [ADDR_BITS-1:0] cnt1_q, cnt1_d;           // next word address, stream 1
  logic                 susp_d;
  logic                 start_d, cont_d, stop_d, valid0_d, valid1_d;
  logic [DW-1:0]        rd_data_d;
  logic [ADDR_BITS-1:0] addr_d;

  logic                 outstanding;
  logic                 cur_open, cur_pstart, cur_pnext, deliver;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      in_flash_q     <= 1'b0;
      open_q         <= 2'b00;
      pstart_q       <= 2'b00;
      pnext_q        <= 2'b00;
      cnt0_q         <= '0;
      cnt1_q         <= '0;
      r1_suspended   <= 1'b0;
      flash_start    <= 1'b0;
      flash_continue <= 1'b0;
      flash_stop     <= 1'b0;
      flash_addr     <= '0;
      r0_valid       <= 1'b0;
      r1_valid       <= 1'b0;
      rd_data        <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      in_flash_q     <= in_flash_d;
      open_q         <= open_d;
      pstart_q       <= pstart_d;
      pnext_q        <= pnext_d;
      cnt0_q         <= cnt0_d;
      cnt1_q         <= cnt1_d;
      r1_suspended   <= susp_d;
      flash_start    <= start_d;
      flash_continue <= cont_d;
      flash_stop     <= stop_d;
      flash_addr     <= addr_d;
      r0_valid       <= valid0_d;
      r1_valid       <= valid1_d;
      rd_data        <= rd_data_d;
    end
  end

  // Request latching, command sequencing and word delivery
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    in_flash_d = in_flash_q;
    open_d     = open_q;
    pstart_d   = pstart_q;
    pnext_d    = pnext_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    susp_d     = r1_suspended;
    start_d    = 1'b0;
    cont_d     = 1'b0;
    stop_d     = 1'b0;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    rd_data_d  = rd_data;
    addr_d     = flash_addr;
    cur_open   = 1'b0;
    cur_pstart = 1'b0;
    cur_pnext  = 1'b0;
    deliver    = 1'b0;

    // A word is in flight from its command pulse until busy drops
    outstanding = (state_q == ISSUE) || (state_q == WAIT);

    // Stream 0 requests; next is dropped while that stream's word is in flight
    if (r0_start) begin
      open_d[0]   = 1'b1;
      pstart_d[0] = 1'b1;
      pnext_d[0]  = 1'b0;
      cnt0_d      = r0_addr;
    end else if (r0_stop) begin
      open_d[0]   = 1'b0;
      pstart_d[0] = 1'b0;
      pnext_d[0]  = 1'b0;
    end else if (r0_next && open_q[0] && !pstart_q[0] && !(outstanding && !owner_q)) begin
      pnext_d[0]  = 1'b1;
    end

    // Stream 1 requests; a stop while suspended closes it without flash traffic
    if (r1_start) begin
      open_d[1]   = 1'b1;
      pstart_d[1] = 1'b1;
      pnext_d[1]  = 1'b0;
      cnt1_d      = r1_addr;
    end else if (r1_stop) begin
      open_d[1]   = 1'b0;
      pstart_d[1] = 1'b0;
      pnext_d[1]  = 1'b0;
      susp_d      = 1'b0;
    end else if (r1_next && open_q[1] && !pstart_q[1] && !(outstanding && owner_q)) begin
      pnext_d[1]  = 1'b1;
    end

    cur_open   = owner_q ? open_d[1]   : open_d[0];
    cur_pstart = owner_q ? pstart_d[1] : pstart_d[0];
    cur_pnext  = owner_q ? pnext_d[1]  : pnext_d[0];

    case (state_q)
      IDLE: begin
        if (!flash_busy) begin
          if (in_flash_q && (!cur_open || cur_pstart ||
                             (PREEMPT_EN && owner_q && pstart_d[0]))) begin
            // Close the session: owner stopped, owner restarting, or stream 0 preempting
            stop_d     = 1'b1;
            in_flash_d = 1'b0;
            state_d    = STOPPING;
            if (PREEMPT_EN && owner_q && open_d[1] && !pstart_d[1]) begin
              susp_d = 1'b1;
            end
          end else if (in_flash_q) begin
            if (cur_pnext) begin
              cont_d           = 1'b1;
              pnext_d[owner_q] = 1'b0;
              state_d          = ISSUE;
            end
          end else if (pstart_d[0]) begin
            start_d     = 1'b1;
            addr_d      = cnt0_d;
            owner_d     = 1'b0;
            in_flash_d  = 1'b1;
            pstart_d[0] = 1'b0;
            state_d     = ISSUE;
          end else if (!open_d[0] && (pstart_d[1] || (susp_d && pnext_d[1]))) begin
            // Fresh stream-1 start, or resume of a suspended stream at its counter
            start_d     = 1'b1;
            addr_d      = cnt1_d;
            owner_d     = 1'b1;
            in_flash_d  = 1'b1;
            pstart_d[1] = 1'b0;
            pnext_d[1]  = 1'b0;
            susp_d      = 1'b0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!flash_busy) begin
          state_d = IDLE;
          // A word for a stream that was stopped or restarted is dropped
          deliver = cur_open && !cur_pstart;
          if (deliver) begin
            rd_data_d = flash_data;
            if (owner_q) begin
              valid1_d = 1'b1;
              cnt1_d   = cnt1_q + ADDR_BITS'(DATA_WIDTH_BYTES);
            end else begin
              valid0_d = 1'b1;
              cnt0_d   = cnt0_q + ADDR_BITS'(DATA_WIDTH_BYTES);
            end
          end
        end
      end
      STOPPING: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_stream_arbiter.sv
module tb_spi_stream_arbiter;

  localparam int unsigned DWB = 2;
  localparam int unsigned AB  = 24;
  localparam int unsigned DW  = 8 * DWB;

  logic          clk, rst_n;
  logic          r0_start, r0_next, r0_stop, r1_start, r1_next, r1_stop;
  logic [AB-1:0] r0_addr, r1_addr;
  logic          r0_valid, r1_valid, r1_suspended;
  logic [DW-1:0] rd_data;
  logic          flash_start, flash_continue, flash_stop;
  logic [AB-1:0] flash_addr;
  logic          fm_busy;
  logic [DW-1:0] fm_data;

  spi_stream_arbiter #(.DATA_WIDTH_BYTES(DWB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_start(r0_start), .r0_addr(r0_addr), .r0_next(r0_next), .r0_stop(r0_stop),
    .r1_start(r1_start), .r1_addr(r1_addr), .r1_next(r1_next), .r1_stop(r1_stop),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .rd_data(rd_data),
    .r1_suspended(r1_suspended),
    .flash_start(flash_start), .flash_continue(flash_continue), .flash_stop(flash_stop),
    .flash_addr(flash_addr), .flash_busy(fm_busy), .flash_data(fm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash controller model: busy for 3 cycles per word, word = addr[15:0] ^ 16'h5A5A
  logic [1:0]    fm_cd;
  logic [AB-1:0] fm_cur;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_busy <= 1'b0; fm_cd <= 2'd0; fm_cur <= '0; fm_data <= '0;
    end else if (flash_start) begin
      fm_cur <= flash_addr; fm_busy <= 1'b1; fm_cd <= 2'd3;
    end else if (flash_continue) begin
      fm_cur <= fm_cur + 24'd2; fm_busy <= 1'b1; fm_cd <= 2'd3;
    end else if (flash_stop) begin
      fm_busy <= 1'b1; fm_cd <= 2'd1;
    end else if (fm_busy) begin
      fm_cd <= fm_cd - 2'd1;
      if (fm_cd == 2'd1) begin
        fm_busy <= 1'b0;
        fm_data <= fm_cur[15:0] ^ 16'h5A5A;
      end
    end
  end

  // Command log: code 1 start, 2 continue, 3 stop
  int            ev_code[$];
  logic [AB-1:0] ev_addr[$];
  int            n_v0;
  int            viol;
  initial begin n_v0 = 0; viol = 0; end
  always @(negedge clk) begin
    if (rst_n) begin
      if (flash_start)    begin ev_code.push_back(1); ev_addr.push_back(flash_addr); end
      if (flash_continue) begin ev_code.push_back(2); ev_addr.push_back('0); end
      if (flash_stop)     begin ev_code.push_back(3); ev_addr.push_back('0); end
      if ((flash_start || flash_continue || flash_stop) && fm_busy) viol++;
      if (int'(flash_start) + int'(flash_continue) + int'(flash_stop) > 1) viol++;
      if (r0_valid) n_v0++;
    end
  end

  function automatic logic [31:0] mk(input int code, input logic [AB-1:0] a);
    return {4'(code), 4'h0, a};
  endfunction

  function automatic logic [31:0] ev_at(input int i);
    if (i < ev_code.size()) return mk(ev_code[i], ev_addr[i]);
    return 32'hFFFF_FFFF;
  endfunction

  int n_vec, n_bad;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle pulse on any combination of requester controls
  task automatic drive(input logic s0, n0, p0, s1, n1, p1);
    @(negedge clk);
    r0_start = s0; r0_next = n0; r0_stop = p0;
    r1_start = s1; r1_next = n1; r1_stop = p1;
    @(negedge clk);
    r0_start = 0; r0_next = 0; r0_stop = 0;
    r1_start = 0; r1_next = 0; r1_stop = 0;
  endtask

  task automatic wait_valid(input int s, input string tag, output logic [DW-1:0] d);
    logic seen;
    seen = 1'b0; d = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((s == 0) ? r0_valid : r1_valid) begin seen = 1'b1; d = rd_data; end
    end
    check({tag, " valid seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (fm_busy) seen = 1'b1;
    end
    check({tag, " busy seen"}, 32'(seen), 32'd1);
  endtask

  logic [DW-1:0] d;
  logic [DW-1:0] t1_exp [4];
  int            b, v0b;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    t1_exp = '{16'h5B5A, 16'h5B58, 16'h5B5E, 16'h5B5C};
    rst_n = 1'b0;
    r0_start = 0; r0_next = 0; r0_stop = 0; r0_addr = '0;
    r1_start = 0; r1_next = 0; r1_stop = 0; r1_addr = '0;
    repeat (3) @(negedge clk);
    check("reset pulses", 32'({flash_start, flash_continue, flash_stop, r0_valid, r1_valid, r1_suspended}), 32'd0);
    check("reset addr", 32'(flash_addr), 32'd0);
    check("reset data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single stream, four words
    b = ev_code.size();
    r0_addr = 24'h000100;
    drive(1, 0, 0, 0, 0, 0);
    check("t1 start latency", {31'd0, flash_start}, 32'd1);
    wait_valid(0, "t1 w0", d);
    check("t1 word0", 32'(d), 32'(t1_exp[0]));
    for (int i = 1; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      check("t1 continue latency", {31'd0, flash_continue}, 32'd1);
      wait_valid(0, "t1 wn", d);
      check("t1 word", 32'(d), 32'(t1_exp[i]));
    end
    check("t1 start ev", ev_at(b), mk(1, 24'h000100));
    check("t1 counter", 32'(dut.cnt0_q), 32'h000108);
    drive(0, 0, 1, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("t1 stop ev", ev_at(b + 4), mk(3, '0));

    // Simultaneous starts: stream 0 first, stream 1 after r0_stop
    b = ev_code.size();
    r0_addr = 24'h000040; r1_addr = 24'h200000;
    drive(1, 0, 0, 1, 0, 0);
    wait_valid(0, "t2 s0", d);
    check("t2 s0 word", 32'(d), 32'h5A1A);
    check("t2 s0 start", ev_at(b), mk(1, 24'h000040));
    drive(0, 0, 1, 0, 0, 0);
    wait_valid(1, "t2 s1", d);
    check("t2 s1 word0", 32'(d), 32'h5A5A);
    check("t2 stop ev", ev_at(b + 1), mk(3, '0));
    check("t2 s1 start", ev_at(b + 2), mk(1, 24'h200000));
    drive(0, 0, 0, 0, 1, 0);
    wait_valid(1, "t2 s1 w1", d);
    check("t2 s1 word1", 32'(d), 32'h5A58);
    check("t2 counter1", 32'(dut.cnt1_q), 32'h200004);

    // r0_start while stream 1 is open
    b = ev_code.size();
    r0_addr = 24'h000000;
    drive(1, 0, 0, 0, 0, 0);
`ifdef SPI_ARB_PREEMPT_EN
    wait_valid(0, "t3 s0", d);
    check("t3 s0 word", 32'(d), 32'h5A5A);
    check("t3 preempt stop", ev_at(b), mk(3, '0));
    check("t3 s0 start", ev_at(b + 1), mk(1, 24'h000000));
    check("t3 suspended", {31'd0, r1_suspended}, 32'd1);
    drive(0, 0, 0, 0, 1, 0);
    repeat (10) @(negedge clk);
    check("t3 next latched only", 32'(ev_code.size()), 32'(b + 2));
    check("t3 still suspended", {31'd0, r1_suspended}, 32'd1);
    drive(0, 0, 1, 0, 0, 0);
    wait_valid(1, "t3 resume", d);
    check("t3 resume word", 32'(d), 32'h5A5E);
    check("t3 s0 stop", ev_at(b + 2), mk(3, '0));
    check("t3 resume start", ev_at(b + 3), mk(1, 24'h200004));
    check("t3 unsuspended", {31'd0, r1_suspended}, 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    repeat (10) @(negedge clk);
`else
    repeat (15) @(negedge clk);
    check("t3 no flash activity", 32'(ev_code.size()), 32'(b));
    check("t3 not suspended", {31'd0, r1_suspended}, 32'd0);
    drive(0, 0, 0, 0, 1, 0);
    wait_valid(1, "t3 s1 w2", d);
    check("t3 s1 word2", 32'(d), 32'h5A5E);
    check("t3 continue ev", ev_at(b), mk(2, '0));
    drive(0, 0, 0, 0, 0, 1);
    wait_valid(0, "t3 s0", d);
    check("t3 s0 word", 32'(d), 32'h5A5A);
    check("t3 s1 stop", ev_at(b + 1), mk(3, '0));
    check("t3 s0 start", ev_at(b + 2), mk(1, 24'h000000));
    drive(0, 0, 1, 0, 0, 0);
    repeat (10) @(negedge clk);
`endif

    // r0_stop with a word in flight: word dropped, stop after busy falls
    b = ev_code.size();
    r0_addr = 24'h000300;
    drive(1, 0, 0, 0, 0, 0);
    v0b = n_v0;
    wait_busy("t4");
    drive(0, 0, 1, 0, 0, 0);
    repeat (15) @(negedge clk);
    check("t4 no valid", 32'(n_v0 - v0b), 32'd0);
    check("t4 start ev", ev_at(b), mk(1, 24'h000300));
    check("t4 stop ev", ev_at(b + 1), mk(3, '0));
    check("t4 event count", 32'(ev_code.size()), 32'(b + 2));

    // Reset in the middle of a word
    r0_addr = 24'h000500;
    drive(1, 0, 0, 0, 0, 0);
    wait_busy("t5");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 rst pulses", 32'({flash_start, flash_continue, flash_stop, r0_valid, r1_valid, r1_suspended}), 32'd0);
    check("t5 rst addr", 32'(flash_addr), 32'd0);
    check("t5 rst data", 32'(rd_data), 32'd0);
    check("t5 rst counter0", 32'(dut.cnt0_q), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b = ev_code.size();
    r1_addr = 24'h000010;
    drive(0, 0, 0, 1, 0, 0);
    check("t5 start latency", {31'd0, flash_start}, 32'd1);
    wait_valid(1, "t5 s1", d);
    check("t5 s1 word", 32'(d), 32'h5A4A);
    check("t5 s1 start", ev_at(b), mk(1, 24'h000010));

    check("issue rule violations", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
